// File: rtl/ddn_pkg.sv
// rtl/ddn_pkg.sv - shared DDN constants and helpers for collector and distribution router
package ddn_pkg;

  localparam int DDN_IN_PORTS   = 4;
  localparam int DDN_DATA_WIDTH = 32;
  localparam int DDN_SRC_WIDTH  = 2;
  localparam int DDN_FIFO_ADDR  = 2;
  localparam int DDN_STALL_W    = 16;

  function automatic int ddn_depth(input int addr);
    return 1 << addr;
  endfunction

  // True when a tag of src_w bits can name every one of the ports.
  function automatic bit ddn_src_fits(input int src_w, input int ports);
    return (1 << src_w) >= ports;
  endfunction

endpackage

// File: rtl/ddn_fifo.sv
// rtl/ddn_fifo.sv - synchronous per-port FIFO with push/pop, occupancy count and head word
module ddn_fifo
  import ddn_pkg::*;
#(
  parameter int DATA_WIDTH = DDN_DATA_WIDTH,
  parameter int ADDR       = DDN_FIFO_ADDR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [ADDR:0]         count
);

  localparam int DEPTH = ddn_depth(ADDR);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR-1:0]       wr_ptr;
  logic [ADDR-1:0]       rd_ptr;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ddn_collector.sv
// rtl/ddn_collector.sv - round-robin gather of PE result ports; optional stall_cnt via DDN_COLLECTOR_STALL_CNT_EN
module ddn_collector
  import ddn_pkg::*;
#(
  parameter int IN_PORTS   = DDN_IN_PORTS,
  parameter int DATA_WIDTH = DDN_DATA_WIDTH,
  parameter int SRC_WIDTH  = DDN_SRC_WIDTH,
  parameter int FIFO_ADDR  = DDN_FIFO_ADDR
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [IN_PORTS*DATA_WIDTH-1:0] in_bus,
  input  logic [IN_PORTS-1:0]            in_valid,
  output logic [IN_PORTS-1:0]            in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [SRC_WIDTH-1:0]           out_src
`ifdef DDN_COLLECTOR_STALL_CNT_EN
  ,
  output logic [DDN_STALL_W-1:0]         stall_cnt
`endif
);

  localparam int                 DEPTH    = ddn_depth(FIFO_ADDR);
  localparam logic [FIFO_ADDR:0] FULL_CNT = (FIFO_ADDR+1)'(DEPTH);

  if (!ddn_src_fits(SRC_WIDTH, IN_PORTS)) begin : g_src_chk
    $error("ddn_collector: SRC_WIDTH too narrow for IN_PORTS");
  end

  logic [DATA_WIDTH-1:0] heads  [IN_PORTS];
  logic [FIFO_ADDR:0]    counts [IN_PORTS];
  logic [IN_PORTS-1:0]   nonempty;
  logic [IN_PORTS-1:0]   push;
  logic [IN_PORTS-1:0]   pop;
  logic [SRC_WIDTH-1:0]  last_grant;
  logic [SRC_WIDTH-1:0]  grant_idx;
  logic                  grant_any;
  logic                  load;

  for (genvar i = 0; i < IN_PORTS; i++) begin : g_port
    assign in_ready[i] = (counts[i] != FULL_CNT);
    assign nonempty[i] = (counts[i] != '0);
    assign push[i]     = in_valid[i] & in_ready[i];
    assign pop[i]      = load && (grant_idx == SRC_WIDTH'(i));

    ddn_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR       (FIFO_ADDR)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[i]),
      .push_data (in_bus[i*DATA_WIDTH +: DATA_WIDTH]),
      .pop       (pop[i]),
      .head      (heads[i]),
      .count     (counts[i])
    );
  end

  // Round robin as two priority searches: lowest non-empty port above
  // last_grant, else lowest non-empty port overall (wrap-around).
  always_comb begin
    logic                 hi_found;
    logic [SRC_WIDTH-1:0] hi_idx;
    logic [SRC_WIDTH-1:0] lo_idx;
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    grant_any = 1'b0;
    for (int j = IN_PORTS - 1; j >= 0; j--) begin
      if (nonempty[j]) begin
        grant_any = 1'b1;
        lo_idx    = SRC_WIDTH'(j);
        if (j > int'(last_grant)) begin
          hi_found = 1'b1;
          hi_idx   = SRC_WIDTH'(j);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  assign load = grant_any && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      last_grant <= SRC_WIDTH'(IN_PORTS - 1);
    end else if (load) begin
      out_valid  <= 1'b1;
      out_data   <= heads[grant_idx];
      out_src    <= grant_idx;
      last_grant <= grant_idx;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef DDN_COLLECTOR_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
